// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: WIDTH bits split into STAGES carry-registered slices,
// with valid/ready handshake and whole-pipeline stall on output backpressure.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int C = WIDTH / STAGES;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;

  function automatic logic sgn_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign b_eff     = sub ? ~b : b;
  assign c0        = sub ? ~cin : cin;
  assign out_valid = g_stage[STAGES-1].vld_p;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign s         = g_stage[STAGES-1].x_p;
  assign cout      = g_stage[STAGES-1].cy_p;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_p;

  // x_p is a shift register: unconsumed chunks of a sit at the bottom, finished
  // result chunks enter at the top, so after the last slice it holds the full sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]     x_in;
    logic [WIDTH-k*C-1:0] y_in;
    logic                 c_in;
    logic                 vld_in;
    logic [C:0]           sum;
    logic [WIDTH-1:0]     x_next;
    logic                 vld_p;
    logic                 cy_p;
    logic [WIDTH-1:0]     x_p;

    if (k == 0) begin : g_src
      assign x_in   = a;
      assign y_in   = b_eff;
      assign c_in   = c0;
      assign vld_in = in_valid;
    end else begin : g_src
      assign x_in   = g_stage[k-1].x_p;
      assign y_in   = g_stage[k-1].g_skew.y_p;
      assign c_in   = g_stage[k-1].cy_p;
      assign vld_in = g_stage[k-1].vld_p;
    end

    assign sum = {1'b0, x_in[C-1:0]} + {1'b0, y_in[C-1:0]} + {{C{1'b0}}, c_in};

    if (STAGES == 1) begin : g_pack
      assign x_next = sum[C-1:0];
    end else begin : g_pack
      assign x_next = {sum[C-1:0], x_in[WIDTH-1:C]};
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        cy_p  <= 1'b0;
        x_p   <= '0;
      end else if (adv) begin
        vld_p <= vld_in;
        cy_p  <= sum[C];
        x_p   <= x_next;
      end
    end

    // Remaining upper chunks of b_eff skew forward to the slices that consume them.
    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-(k+1)*C-1:0] y_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_p <= '0;
        end else if (adv) begin
          y_p <= y_in[WIDTH-k*C-1:C];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_p <= 1'b0;
        end else if (adv) begin
          ovf_p <= sgn_ovf(x_in[C-1], y_in[C-1], sum[C-1]);
        end
      end
    end
  end

endmodule
